iot_event_encoder: RTL and testbench
====================================

# iot_event_encoder

- Transmitter side of the active-device monitor's change/on_off interface.
- Watches the level-sensitive "active" line of up to N_DEV IoT devices and detects every transition.
- Emits transitions one per cycle as a single-cycle `change` pulse with `on_off` giving the direction, so the downstream monitor counter stays equal to the number of active devices.
- Keeps a shadow of the net count for cross-checking.

## Interface
Parameters:
- N_DEV, 8, number of monitored devices (2..255)
- ID_W, 3, width of dev_id; must satisfy 2^ID_W >= N_DEV

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dev_active  in  N_DEV  per-device level; 1 = device active; synchronous to clk
- hold  in  1  1 = suppress event emission; transitions are still tracked
- change  out  1  single-cycle pulse: one device changed state
- on_off  out  1  direction of the event; 1 = device turned on, 0 = turned off; valid while change=1
- dev_id  out  ID_W  index of the device the event refers to; valid while change=1
- pending  out  N_DEV  per-device flag: a transition not yet emitted
- net_active  out  8  number of devices currently reported active

## Operation
Register stage:
- dev_q <= dev_active every cycle.
- reported[N_DEV] holds the last level sent for each device.
- pending = dev_q ^ reported (combinational).

Each rising edge, when hold=0 and |pending:
- Select index i: the first set bit of pending, searching upward from rr_ptr and wrapping past N_DEV-1 to 0.
- change <= 1, on_off <= dev_q[i], dev_id <= i.
- reported[i] <= dev_q[i]; rr_ptr <= (i+1) mod N_DEV.
- net_active <= net_active + 1 if dev_q[i] = 1, otherwise net_active - 1.

Otherwise:
- change <= 0; on_off and dev_id hold their values; reported, rr_ptr and net_active unchanged.

Behaviour rules:
- No FSM states beyond the round-robin pointer; the block is a rate-limited transition encoder.
- Cancellation: a device that toggles and returns before it is served produces no event. Only the net level change relative to `reported` is ever sent.
- Fairness: a continuously toggling device cannot starve others. With all devices pending, the maximum wait is N_DEV cycles.
- hold=1 freezes emission indefinitely. pending accumulates; on release, emission resumes from the current rr_ptr.
- net_active never over- or underflows. It always equals popcount(reported) <= N_DEV <= 255.
- Invariant a bench can check: an up/down counter driven by change/on_off always equals net_active.

## Timing
- Reset (rst=0, asynchronous): change=0, on_off=0, dev_id=0, net_active=0, pending=0, dev_q=0, reported=0, rr_ptr=0.
- Devices already active when rst deasserts produce "on" events in the cycles after the first sampling edge.
- Latency:
  - dev_active changes before edge k; dev_q updates at edge k; pending is visible after edge k.
  - change is high after edge k+1, when the device is selected immediately.
  - Minimum latency is 2 cycles.
- change is never high for the same device in two consecutive cycles unless its level changed again in between.
- Throughput: at most one event per cycle; with no new transitions, K pending transitions drain in K cycles.
- Simultaneous events:
  - A new transition on device i in the same cycle device i is served: the new dev_q is compared against the updated reported on the next cycle, so it becomes a fresh pending event.
  - hold rising in the same cycle as a selection: hold is sampled at the edge; if 1, no event.
- Reset asserted mid-drain: all pending events are discarded and net_active returns to 0; the downstream monitor must be reset together with this block.

## Structure
- Shared package `iot_pkg`:
  - COUNT_W = 8, the shared width of the monitor counter and net_active
  - default N_DEV and ID_W
- Sub-module `rr_pick`:
  - Purely combinational round-robin first-set finder.
  - Inputs: req[N_DEV] and ptr[ID_W].
  - Outputs: grant_valid and grant_idx[ID_W].
- The top level holds dev_q, reported, rr_ptr, the output registers and the net_active up/down counter.

## Test plan
- Reset: drive rst=0 with dev_active=8'hFF mid-operation -> all outputs 0 immediately. After rst=1, exactly 8 change pulses over 8 consecutive cycles with on_off=1 and dev_id 0..7 in order; net_active ends at 8.
- Single toggle: from idle with N_DEV=8, raise dev_active[5] -> change=1 two cycles later with on_off=1 and dev_id=5; lower it -> one pulse with on_off=0; net_active goes 0 -> 1 -> 0.
- Cancellation: hold=1, pulse dev_active[2] high for 3 cycles then low, release hold -> no change pulse; pending stays 0 after the low level is sampled.
- Round-robin: with rr_ptr=6, raise devices 1, 6 and 7 in the same cycle -> events in order 6, 7, 1; net_active=3.
- Hold backlog: hold=1, raise all 8 devices, wait 20 cycles -> change stays 0 and pending=8'hFF. Release hold -> 8 back-to-back pulses, then pending=0 and net_active=8.
- Scoreboard: random dev_active toggling for 10k cycles -> a reference up/down counter fed by change/on_off always equals net_active and equals popcount(reported), checked every cycle.

Source files
------------

// File: rtl/iot_pkg.sv
// iot_pkg
// Shared constants for the IoT active-device monitor path.
//   COUNT_W   : width of the downstream monitor counter and of net_active
//   DEF_N_DEV : default number of monitored devices
//   DEF_ID_W  : default width of a device index (2^DEF_ID_W >= DEF_N_DEV)
package iot_pkg;

  localparam int COUNT_W   = 8;
  localparam int DEF_N_DEV = 8;
  localparam int DEF_ID_W  = 3;

endpackage

// File: rtl/iot_event_encoder_rr_pick.sv
// rr_pick
// Purely combinational round-robin first-set finder.
// Ports:
//   req         in  N_DEV  request vector
//   ptr         in  ID_W   index the search starts from (must be < N_DEV)
//   grant_valid out 1      at least one request is set
//   grant_idx   out ID_W   first set request at or after ptr, wrapping to 0
module rr_pick
  import iot_pkg::*;
#(
  parameter int N_DEV = DEF_N_DEV,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic [N_DEV-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

  int idx;

  // Walk the requests in priority order starting at ptr; the first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_DEV; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_DEV) idx = idx - N_DEV;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iot_event_encoder.sv
// iot_event_encoder
// Turns level changes on per-device "active" lines into a stream of
// single-cycle change/on_off events, one per cycle, served round-robin.
// Ports:
//   clk        in  1        system clock, rising edge
//   rst        in  1        asynchronous active-low reset
//   dev_active in  N_DEV    per-device activity level
//   hold       in  1        1 = suppress emission (transitions still tracked)
//   change     out 1        one-cycle event pulse
//   on_off     out 1        event direction, 1 = turned on
//   dev_id     out ID_W     device the event refers to
//   pending    out N_DEV    transitions not yet emitted
//   net_active out COUNT_W  devices currently reported active
module iot_event_encoder
  import iot_pkg::*;
#(
  parameter int N_DEV = DEF_N_DEV,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DEV-1:0]   dev_active,
  input  logic               hold,
  output logic               change,
  output logic               on_off,
  output logic [ID_W-1:0]    dev_id,
  output logic [N_DEV-1:0]   pending,
  output logic [COUNT_W-1:0] net_active
);

  logic [N_DEV-1:0] dev_q;
  logic [N_DEV-1:0] reported;
  logic [ID_W-1:0]  rr_ptr;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic             fire;
  logic [ID_W-1:0]  next_ptr;

  // Only the net difference between the sampled level and what was last
  // sent is pending, so a toggle that returns before service cancels itself.
  assign pending = dev_q ^ reported;

  rr_pick #(
    .N_DEV(N_DEV),
    .ID_W (ID_W)
  ) u_pick (
    .req        (pending),
    .ptr        (rr_ptr),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign fire     = !hold && grant_valid;
  assign next_ptr = (grant_idx == ID_W'(N_DEV - 1)) ? '0 : grant_idx + ID_W'(1);

  // Sample the device levels every cycle, independent of hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dev_q <= '0;
    else      dev_q <= dev_active;
  end

  // Emit at most one event per cycle; on_off/dev_id keep their last value
  // when idle. net_active follows reported exactly, so it cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reported   <= '0;
      rr_ptr     <= '0;
      change     <= 1'b0;
      on_off     <= 1'b0;
      dev_id     <= '0;
      net_active <= '0;
    end else if (fire) begin
      reported[grant_idx] <= dev_q[grant_idx];
      rr_ptr              <= next_ptr;
      change              <= 1'b1;
      on_off              <= dev_q[grant_idx];
      dev_id              <= grant_idx;
      net_active          <= dev_q[grant_idx] ? net_active + COUNT_W'(1)
                                              : net_active - COUNT_W'(1);
    end else begin
      change <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iot_event_encoder.sv
// tb_iot_event_encoder
// Randomised and directed stimulus for iot_event_encoder, with a queue-based
// scoreboard fed by a behavioural model and an independent up/down counter.
module tb_iot_event_encoder;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] dev_active;
  logic         hold;
  logic         change;
  logic         on_off;
  logic [2:0]   dev_id;
  logic [N-1:0] pending;
  logic [7:0]   net_active;

  iot_event_encoder #(.N_DEV(N), .ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .dev_active(dev_active),
    .hold      (hold),
    .change    (change),
    .on_off    (on_off),
    .dev_id    (dev_id),
    .pending   (pending),
    .net_active(net_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         chg;
    logic         on;
    int           id;
    int           net;
    logic [N-1:0] pend;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   checking   = 0;

  // Reference model state: what the devices look like as last sampled,
  // which level was last announced per device, and where fairness resumes.
  bit [N-1:0] seenLevel;
  bit [N-1:0] announced;
  int         nextStart;
  bit         lastOn;
  int         lastId;
  int         refCount;
  int         eventCount;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    seenLevel = '0;
    announced = '0;
    nextStart = 0;
    lastOn    = 0;
    lastId    = 0;
  endtask

  // Drive one cycle of inputs, predict what the next edge does, queue it.
  task automatic applyStimulus(input logic [N-1:0] din, input logic h);
    exp_t e;
    bit [N-1:0] diff;
    dev_active = din;
    hold       = h;
    diff  = seenLevel ^ announced;
    e.chg = 0;
    if (!h && diff != 0) begin
      for (int k = 0; k < N; k++) begin
        int d;
        d = (nextStart + k) % N;
        if (!e.chg && diff[d]) begin
          e.chg        = 1;
          lastOn       = seenLevel[d];
          lastId       = d;
          announced[d] = seenLevel[d];
          nextStart    = (d + 1) % N;
        end
      end
    end
    seenLevel = din;
    e.on   = lastOn;
    e.id   = lastId;
    e.net  = $countones(announced);
    e.pend = seenLevel ^ announced;
    expQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name);
    check({name, ".change"}, change, 0);
    check({name, ".on_off"}, on_off, 0);
    check({name, ".dev_id"}, dev_id, 0);
    check({name, ".net"},    net_active, 0);
    check({name, ".pend"},   pending, 0);
  endtask

  // Monitor: after every edge compare the DUT against the oldest prediction.
  initial begin
    refCount   = 0;
    eventCount = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        refCount = 0;
      end else if (checking) begin
        if (change) begin
          refCount += on_off ? 1 : -1;
          eventCount++;
        end
        check("refcount", refCount, net_active);
        if (expQ.size() == 0) begin
          check("queue_empty", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("change", change, e.chg);
          if (e.chg) begin
            check("on_off", on_off, e.on);
            check("dev_id", dev_id, e.id);
          end else begin
            check("on_off_hold", on_off, e.on);
            check("dev_id_hold", dev_id, e.id);
          end
          check("net_active", net_active, e.net);
          check("pending", pending, e.pend);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] din;
    int holdLeft;
    int startEvents;
    rst        = 1'b0;
    dev_active = '0;
    hold       = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    @(negedge clk);
    rst      = 1'b1;
    checking = 1;

    // Single toggle on device 5, up then down.
    repeat (2) applyStimulus(8'h00, 1'b0);
    repeat (3) applyStimulus(8'h20, 1'b0);
    check("single_up_net", net_active, 1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    check("single_down_net", net_active, 0);

    // Pointer now sits at 6: devices 1, 6, 7 must come out as 6, 7, 1.
    startEvents = eventCount;
    repeat (5) applyStimulus(8'hC2, 1'b0);
    check("rr_net", net_active, 3);
    check("rr_events", eventCount - startEvents, 3);
    repeat (5) applyStimulus(8'h00, 1'b0);

    // Cancellation under hold: no event for device 2.
    startEvents = eventCount;
    applyStimulus(8'h00, 1'b1);
    repeat (3) applyStimulus(8'h04, 1'b1);
    repeat (2) applyStimulus(8'h00, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    check("cancel_events", eventCount - startEvents, 0);

    // Hold backlog of all devices, then drain back to back.
    repeat (20) applyStimulus(8'hFF, 1'b1);
    check("backlog_pend", pending, 8'hFF);
    repeat (10) applyStimulus(8'hFF, 1'b0);
    check("backlog_net", net_active, 8);

    // Asynchronous reset in the middle of operation.
    dev_active = 8'h0F;
    repeat (2) applyStimulus(8'h0F, 1'b0);
    checking   = 0;
    dev_active = 8'hFF;
    rst        = 1'b0;
    #1;
    checkOutput("midreset");
    expQ.delete();
    modelReset();
    @(negedge clk);
    rst      = 1'b1;
    checking = 1;
    startEvents = eventCount;
    repeat (10) applyStimulus(8'hFF, 1'b0);
    check("post_reset_events", eventCount - startEvents, 8);
    check("post_reset_net", net_active, 8);

    // Random toggling with occasional hold bursts.
    din      = 8'hFF;
    holdLeft = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) din[b] = ~din[b];
      if (holdLeft > 0) holdLeft--;
      else if ($urandom_range(0, 39) == 0) holdLeft = $urandom_range(1, 25);
      applyStimulus(din, holdLeft > 0);
    end
    repeat (12) applyStimulus(din, 1'b0);
    check("final_net", net_active, $countones(din));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
